// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the posted-store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  // Word-address slice of a byte address.
  localparam int WA_HI  = 31;
  localparam int WA_LO  = 2;
  localparam int ADDR_W = WA_HI - WA_LO + 1;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } sb_entry_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[WA_HI:WA_LO];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline and data-memory signals of the store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              St_Req;
  logic [31:0]       St_Ad;
  logic [DATA_W-1:0] St_Wd;
  logic [PC_W-1:0]   St_Pc;
  logic              St_Ready;
  logic              Ld_Req;
  logic [31:0]       Ld_Ad;
  logic [DATA_W-1:0] Ld_Rd;
  logic [31:0]       Dm_Ad;
  logic [DATA_W-1:0] Dm_Wd;
  logic              Dm_Wr;
  logic [PC_W-1:0]   Dm_Pc;
  logic [DATA_W-1:0] Dm_Rd;
  logic              Empty;

  // Pipeline plus memory side.
  modport master (
    output St_Req, St_Ad, St_Wd, St_Pc, Ld_Req, Ld_Ad, Dm_Rd,
    input  St_Ready, Ld_Rd, Dm_Ad, Dm_Wd, Dm_Wr, Dm_Pc, Empty
  );

  // The store buffer itself.
  modport slave (
    input  St_Req, St_Ad, St_Wd, St_Pc, Ld_Req, Ld_Ad, Dm_Rd,
    output St_Ready, Ld_Rd, Dm_Ad, Dm_Wd, Dm_Wr, Dm_Pc, Empty
  );
endinterface

// File: rtl/store_buffer_match.sv
// DEPTH-way load address compare with youngest-match select.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = 2
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [PTR_W:0]    count_i,
  input  logic [ADDR_W-1:0] ld_wa_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  // Walk oldest to youngest so the last valid match (closest to tail) wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_i + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_i) && (entries_i[idx].addr == ld_wa_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer between the MEM stage and data memory. Owns the
// data-memory port; loads take the port and forward from pending stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  sb_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push, drain;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;

  // Handshake decisions and next pointer/count values. Reset suppresses
  // drain so discarded stores never reach memory.
  always_comb begin
    push    = !Reset && sb.St_Req && (count_q != FULL);
    drain   = !Reset && (count_q != '0) && !sb.Ld_Req;
    head_d  = drain ? head_q + 1'b1 : head_q;
    tail_d  = push  ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !drain)      count_d = count_q + 1'b1;
    else if (drain && !push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity is implied by head/count, so no reset needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      entries_q[tail_q] <= '{addr: word_addr(sb.St_Ad), data: sb.St_Wd, pc: sb.St_Pc};
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .ld_wa_i   (word_addr(sb.Ld_Ad)),
    .hit_o     (hit),
    .data_o    (fwd_data)
  );

  // Memory port mux: load address first, otherwise the head entry, else idle zeros.
  always_comb begin
    sb.Dm_Ad = '0;
    sb.Dm_Wd = '0;
    sb.Dm_Pc = '0;
    sb.Dm_Wr = 1'b0;
    if (sb.Ld_Req) begin
      sb.Dm_Ad = {word_addr(sb.Ld_Ad), 2'b00};
    end else if (drain) begin
      sb.Dm_Wr = 1'b1;
      sb.Dm_Ad = {entries_q[head_q].addr, 2'b00};
      sb.Dm_Wd = entries_q[head_q].data;
      sb.Dm_Pc = entries_q[head_q].pc;
    end
  end

  assign sb.Ld_Rd    = hit ? fwd_data : sb.Dm_Rd;
  assign sb.St_Ready = (count_q != FULL);
  assign sb.Empty    = (count_q == '0);

endmodule
